pulse_profile_sequencer: RTL and testbench
==========================================

PULSE_PROFILE_SEQUENCER -- requirements
Module: pulse_profile_sequencer

Interface
REQ-001 clk  input  1  rising-edge system clock; all state changes on posedge clk.
REQ-002 RST  input  1  synchronous, active-high reset.
REQ-003 wr_en  input  1  profile write request, qualified by wr_ready.
REQ-004 wr_addr  input  4  {profile[3:2], channel[1:0]}; channel 0..2 valid, 3 reserved.
REQ-005 wr_data  input  12  {width[11:8], period[7:4], phase[3:0]} for the addressed channel.
REQ-006 wr_ready  output  1  high when a write presented this cycle is accepted.
REQ-007 start  input  1  begin sequencing at profile 0.
REQ-008 stop  input  1  abort sequencing.
REQ-009 loop  input  1  1 = wrap to profile 0 after last_prof, 0 = finish.
REQ-010 last_prof  input  2  index of final profile in sequence.
REQ-011 dwell  input  8  RUN cycles per profile; 0 means 256.
REQ-012 SET  output  1  one-cycle load strobe to the 3-channel pulse generator.
REQ-013 PulseW  output  12  {ch3, ch2, ch1} widths, 4 bits each.
REQ-014 Period  output  12  {ch3, ch2, ch1} periods, 4 bits each.
REQ-015 Phase  output  12  {ch3, ch2, ch1} phases, 4 bits each.
REQ-016 cur_prof  output  2  profile currently loaded or being loaded.
REQ-017 busy  output  1  high in LOAD and RUN.
REQ-018 done  output  1  one-cycle pulse on non-loop sequence completion.

Function
REQ-019 Storage: 4 profiles x 3 channels x 12 bits; writes complete on the clock edge where wr_en and wr_ready are both high.
REQ-020 wr_ready is low only when busy=1 and wr_addr[3:2]==cur_prof; otherwise high.
REQ-021 A write with wr_en=1 and wr_ready=0 is dropped; the requester holds wr_en until it is accepted.
REQ-022 A write to channel 3 is accepted (wr_ready per REQ-020) and discarded.
REQ-023 Field values are stored unchecked; phase>period and width>=period pass through unchanged.
REQ-024 FSM states: IDLE, LOAD, RUN; all outputs are registered.
REQ-025 IDLE: start=1 and stop=0 -> LOAD with cur_prof=0; start=1 with stop=1 -> remain IDLE.
REQ-026 LOAD lasts exactly one cycle: SET=1, and PulseW/Period/Phase show profile cur_prof in that same cycle; next state RUN with the dwell counter cleared.
REQ-027 RUN: the counter increments every cycle; the dwell value is sampled on entry to RUN; RUN lasts exactly dwell cycles (256 if 0).
REQ-028 Last RUN cycle with cur_prof!=last_prof -> LOAD with cur_prof+1.
REQ-029 Last RUN cycle with cur_prof==last_prof and loop=1 -> LOAD with cur_prof=0.
REQ-030 Last RUN cycle with cur_prof==last_prof and loop=0 -> IDLE, with done=1 for the first IDLE cycle.
REQ-031 stop=1 in LOAD or RUN -> IDLE next cycle: no further SET, done=0, PulseW/Period/Phase/cur_prof hold their last values.
REQ-032 start while busy is ignored.
REQ-033 Latency: start sampled at edge k -> SET high in the cycle following edge k; SET period per profile = dwell+1 cycles.
REQ-034 A write to a non-active profile during RUN takes effect at that profile's next LOAD.
REQ-035 last_prof and loop are sampled at each last-RUN-cycle decision, not latched at start.

Reset
REQ-036 When RST=1 at a clock edge: state IDLE, all profile storage 0, SET=0, PulseW/Period/Phase=0, cur_prof=0, busy=0, done=0.
REQ-037 RST overrides start, stop and wr_en in the same cycle; reset mid-RUN aborts without a SET or done pulse.

Verification
REQ-038 Write profile 0 ch1 = 0x352, dwell=4, last_prof=0, loop=0, pulse start -> SET high 1 cycle, PulseW[3:0]=3, Period[3:0]=5, Phase[3:0]=2; 4 RUN cycles; then done=1 for 1 cycle, busy=0.
REQ-039 Distinct values in profiles 0..2, last_prof=2, loop=1, dwell=3 -> SET every 4 cycles, cur_prof sequence 0,1,2,0,1; outputs track each profile.
REQ-040 During RUN of profile 1, write profile 1 -> wr_ready=0, storage unchanged; write profile 2 -> accepted, and the new value appears at profile 2's LOAD.
REQ-041 stop asserted on the 2nd RUN cycle -> IDLE next cycle, no SET, no done, outputs held; start and stop together in IDLE -> stays IDLE.
REQ-042 dwell=0 -> 256 RUN cycles between SET pulses; RST asserted mid-RUN -> all outputs 0 next cycle and storage cleared.

Source files
------------

// File: rtl/pulse_profile_sequencer.sv
// Pulse profile sequencer: stores four 3-channel pulse profiles and plays them in
// order, loading each into the downstream pulse generator for a programmable dwell time.
module pulse_profile_sequencer (
    input  logic        clk,
    input  logic        RST,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [11:0] wr_data,
    output logic        wr_ready,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic [1:0]  last_prof,
    input  logic [7:0]  dwell,
    output logic        SET,
    output logic [11:0] PulseW,
    output logic [11:0] Period,
    output logic [11:0] Phase,
    output logic [1:0]  cur_prof,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Indexed by {profile, channel}; channel-3 slots are never written and never read.
    logic [11:0] prof_mem_r [0:15];
    logic [1:0]  state_r;
    logic [7:0]  cnt_r;
    logic [7:0]  dwell_r;
    logic        set_r;
    logic        done_r;
    logic        busy_r;
    logic [1:0]  cur_prof_r;
    logic [11:0] pulse_w_r;
    logic [11:0] period_r;
    logic [11:0] phase_r;

    logic        wr_ready_s;
    logic        wr_accept_s;
    logic        last_run_s;
    logic [1:0]  state_nxt_s;
    logic        load_s;
    logic [1:0]  load_prof_s;
    logic        done_s;
    logic [11:0] ld_ch0_s;
    logic [11:0] ld_ch1_s;
    logic [11:0] ld_ch2_s;

    // Write handshake: only the profile being played is locked against writes.
    always_comb begin
        wr_ready_s  = !(busy_r && (wr_addr[3:2] == cur_prof_r));
        wr_accept_s = wr_en && wr_ready_s && (wr_addr[1:0] != 2'd3);
    end

    assign wr_ready = wr_ready_s;

    // Next-state decision; dwell_r - 1 wraps to 255 so a dwell of 0 gives 256 RUN cycles.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        load_prof_s = cur_prof_r;
        done_s      = 1'b0;
        last_run_s  = (state_r == ST_RUN) && (cnt_r == (dwell_r - 8'd1));
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt_s = ST_LOAD;
                    load_s      = 1'b1;
                    load_prof_s = 2'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (!last_run_s) begin
                    state_nxt_s = ST_RUN;
                end else if (cur_prof_r != last_prof) begin
                    state_nxt_s = ST_LOAD;
                    load_s      = 1'b1;
                    load_prof_s = cur_prof_r + 2'd1;
                end else if (loop) begin
                    state_nxt_s = ST_LOAD;
                    load_s      = 1'b1;
                    load_prof_s = 2'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                    done_s      = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Channel words of the profile about to be loaded.
    always_comb begin
        ld_ch0_s = prof_mem_r[{load_prof_s, 2'd0}];
        ld_ch1_s = prof_mem_r[{load_prof_s, 2'd1}];
        ld_ch2_s = prof_mem_r[{load_prof_s, 2'd2}];
    end

    // Profile storage.
    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                prof_mem_r[i] <= 12'd0;
            end
        end else if (wr_accept_s) begin
            prof_mem_r[wr_addr] <= wr_data;
        end
    end

    // Sequencer state, dwell counter and registered outputs.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            dwell_r    <= 8'd0;
            set_r      <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            cur_prof_r <= 2'd0;
            pulse_w_r  <= 12'd0;
            period_r   <= 12'd0;
            phase_r    <= 12'd0;
        end else begin
            state_r <= state_nxt_s;
            set_r   <= load_s;
            done_r  <= done_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (state_r == ST_LOAD) begin
                cnt_r   <= 8'd0;
                dwell_r <= dwell;
            end else if (state_r == ST_RUN) begin
                cnt_r <= cnt_r + 8'd1;
            end
            if (load_s) begin
                cur_prof_r <= load_prof_s;
                pulse_w_r  <= {ld_ch2_s[11:8], ld_ch1_s[11:8], ld_ch0_s[11:8]};
                period_r   <= {ld_ch2_s[7:4],  ld_ch1_s[7:4],  ld_ch0_s[7:4]};
                phase_r    <= {ld_ch2_s[3:0],  ld_ch1_s[3:0],  ld_ch0_s[3:0]};
            end
        end
    end

    assign SET      = set_r;
    assign done     = done_r;
    assign busy     = busy_r;
    assign cur_prof = cur_prof_r;
    assign PulseW   = pulse_w_r;
    assign Period   = period_r;
    assign Phase    = phase_r;

endmodule

// File: tb/tb_pulse_profile_sequencer.sv
// Directed bench for pulse_profile_sequencer: a per-cycle vector table for the
// basic and looping sequences, plus hand sequences for locking, stop, dwell=0 and reset.
module tb_pulse_profile_sequencer;

    logic        clk = 1'b0;
    logic        RST;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic        start;
    logic        stop;
    logic        loop;
    logic [1:0]  last_prof;
    logic [7:0]  dwell;
    logic        SET;
    logic [11:0] PulseW;
    logic [11:0] Period;
    logic [11:0] Phase;
    logic [1:0]  cur_prof;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pulse_profile_sequencer dut (
        .clk(clk), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .start(start), .stop(stop), .loop(loop),
        .last_prof(last_prof), .dwell(dwell), .SET(SET), .PulseW(PulseW),
        .Period(Period), .Phase(Phase), .cur_prof(cur_prof), .busy(busy), .done(done)
    );

    typedef struct {
        logic        start, stop, wen;
        logic [3:0]  addr;
        logic [11:0] data;
        logic [7:0]  dwl;
        logic [1:0]  last;
        logic        lp;
        logic        rdy, set, bsy, dn;
        logic [1:0]  cur;
        logic [11:0] pw, per, ph;
    } vec_t;

    vec_t vecs[$];

    // Profile images as seen on PulseW/Period/Phase.
    localparam logic [11:0] P0_PW = 12'h003, P0_PER = 12'h005, P0_PH = 12'h002;
    localparam logic [11:0] P1_PW = 12'h070, P1_PER = 12'h0A0, P1_PH = 12'h010;
    localparam logic [11:0] P2_PW = 12'h900, P2_PER = 12'hC00, P2_PH = 12'h400;

    function automatic void add(logic st, logic sp, logic we, logic [3:0] a, logic [11:0] d,
                                logic [7:0] dw, logic [1:0] lst, logic l,
                                logic r, logic s, logic b, logic dn, logic [1:0] c,
                                logic [11:0] pw, logic [11:0] per, logic [11:0] ph);
        vec_t v;
        v.start = st; v.stop = sp; v.wen = we; v.addr = a; v.data = d;
        v.dwl = dw; v.last = lst; v.lp = l;
        v.rdy = r; v.set = s; v.bsy = b; v.dn = dn; v.cur = c;
        v.pw = pw; v.per = per; v.ph = ph;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_set(input string name, input int maxc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (SET !== 1'b1 && n < maxc);
        chk(name, {31'd0, SET}, 32'd1);
    endtask

    task automatic chk_outs(input string name, input logic s, input logic b, input logic d,
                            input logic [1:0] c, input logic [11:0] pw,
                            input logic [11:0] per, input logic [11:0] ph);
        chk({name, "_set"},  {31'd0, SET},  {31'd0, s});
        chk({name, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({name, "_done"}, {31'd0, done}, {31'd0, d});
        chk({name, "_cur"},  {30'd0, cur_prof}, {30'd0, c});
        chk({name, "_pw"},   {20'd0, PulseW}, {20'd0, pw});
        chk({name, "_per"},  {20'd0, Period}, {20'd0, per});
        chk({name, "_ph"},   {20'd0, Phase},  {20'd0, ph});
    endtask

    initial begin
        int n;
        logic seen;

        // Single-profile run, dwell 4, no loop.
        add(0,0,1,4'h0,12'h352, 8'd4,2'd0,0, 1,0,0,0,2'd0, 12'h000,12'h000,12'h000);
        add(1,0,0,4'h0,12'h000, 8'd4,2'd0,0, 1,1,1,0,2'd0, P0_PW,P0_PER,P0_PH);
        for (int i = 0; i < 4; i++)
            add(0,0,0,4'h0,12'h000, 8'd4,2'd0,0, 0,0,1,0,2'd0, P0_PW,P0_PER,P0_PH);
        add(0,0,0,4'h0,12'h000, 8'd4,2'd0,0, 0,0,0,1,2'd0, P0_PW,P0_PER,P0_PH);
        add(0,0,0,4'h0,12'h000, 8'd4,2'd0,0, 1,0,0,0,2'd0, P0_PW,P0_PER,P0_PH);
        // Three profiles looping with dwell 3; channel-3 write must be discarded.
        add(0,0,1,4'h5,12'h7A1, 8'd3,2'd2,1, 1,0,0,0,2'd0, P0_PW,P0_PER,P0_PH);
        add(0,0,1,4'hA,12'h9C4, 8'd3,2'd2,1, 1,0,0,0,2'd0, P0_PW,P0_PER,P0_PH);
        add(0,0,1,4'h3,12'hFFF, 8'd3,2'd2,1, 1,0,0,0,2'd0, P0_PW,P0_PER,P0_PH);
        add(1,0,0,4'hC,12'h000, 8'd3,2'd2,1, 1,1,1,0,2'd0, P0_PW,P0_PER,P0_PH);
        for (int i = 0; i < 3; i++)
            add(0,0,0,4'hC,12'h000, 8'd3,2'd2,1, 1,0,1,0,2'd0, P0_PW,P0_PER,P0_PH);
        add(0,0,0,4'hC,12'h000, 8'd3,2'd2,1, 1,1,1,0,2'd1, P1_PW,P1_PER,P1_PH);
        add(0,0,0,4'hC,12'h000, 8'd3,2'd2,1, 1,0,1,0,2'd1, P1_PW,P1_PER,P1_PH);
        add(0,0,0,4'h4,12'h000, 8'd3,2'd2,1, 0,0,1,0,2'd1, P1_PW,P1_PER,P1_PH);
        add(0,0,0,4'hC,12'h000, 8'd3,2'd2,1, 1,0,1,0,2'd1, P1_PW,P1_PER,P1_PH);
        add(0,0,0,4'hC,12'h000, 8'd3,2'd2,1, 1,1,1,0,2'd2, P2_PW,P2_PER,P2_PH);
        for (int i = 0; i < 3; i++)
            add(0,0,0,4'hC,12'h000, 8'd3,2'd2,1, 1,0,1,0,2'd2, P2_PW,P2_PER,P2_PH);
        add(0,0,0,4'hC,12'h000, 8'd3,2'd2,1, 1,1,1,0,2'd0, P0_PW,P0_PER,P0_PH);
        for (int i = 0; i < 3; i++)
            add(0,0,0,4'hC,12'h000, 8'd3,2'd2,1, 1,0,1,0,2'd0, P0_PW,P0_PER,P0_PH);
        add(0,0,0,4'hC,12'h000, 8'd3,2'd2,1, 1,1,1,0,2'd1, P1_PW,P1_PER,P1_PH);
        for (int i = 0; i < 3; i++)
            add(0,0,0,4'hC,12'h000, 8'd3,2'd2,1, 1,0,1,0,2'd1, P1_PW,P1_PER,P1_PH);
        // last_prof/loop changed only at the decision cycle: sequence finishes here.
        add(0,0,0,4'hC,12'h000, 8'd3,2'd1,0, 1,0,0,1,2'd1, P1_PW,P1_PER,P1_PH);
        add(0,0,0,4'hC,12'h000, 8'd3,2'd1,0, 1,0,0,0,2'd1, P1_PW,P1_PER,P1_PH);

        RST = 1'b1; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 12'h000;
        start = 1'b0; stop = 1'b0; loop = 1'b0; last_prof = 2'd0; dwell = 8'd4;
        tick();
        tick();
        chk_outs("reset", 0, 0, 0, 2'd0, 12'h000, 12'h000, 12'h000);
        chk("reset_rdy", {31'd0, wr_ready}, 32'd1);
        RST = 1'b0;

        foreach (vecs[i]) begin
            start = vecs[i].start; stop = vecs[i].stop; wr_en = vecs[i].wen;
            wr_addr = vecs[i].addr; wr_data = vecs[i].data; dwell = vecs[i].dwl;
            last_prof = vecs[i].last; loop = vecs[i].lp;
            #1;
            chk($sformatf("v%0d_rdy", i), {31'd0, wr_ready}, {31'd0, vecs[i].rdy});
            tick();
            chk_outs($sformatf("v%0d", i), vecs[i].set, vecs[i].bsy, vecs[i].dn,
                     vecs[i].cur, vecs[i].pw, vecs[i].per, vecs[i].ph);
        end
        start = 1'b0; wr_en = 1'b0; wr_addr = 4'hC;

        // Writes during RUN of profile 1: own profile locked, profile 2 accepted.
        dwell = 8'd6; last_prof = 2'd2; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("lock_load0", {30'd0, cur_prof, SET}, {30'd0, 2'd0, 1'b1});
        wait_set("lock_set1", 10, n);
        chk("lock_period0", n, 7);
        chk("lock_cur1", {30'd0, cur_prof}, 32'd1);
        tick();
        wr_en = 1'b1; wr_addr = 4'h4; wr_data = 12'hEEE;
        #1;
        chk("lock_rdy_own", {31'd0, wr_ready}, 32'd0);
        tick();
        wr_addr = 4'hA; wr_data = 12'h5B6;
        #1;
        chk("lock_rdy_other", {31'd0, wr_ready}, 32'd1);
        tick();
        wr_en = 1'b0; wr_addr = 4'hC;
        wait_set("lock_set2", 10, n);
        chk("lock_wait2", n, 4);
        chk_outs("lock_load2", 1, 1, 0, 2'd2, 12'h500, 12'hB00, 12'h600);
        repeat (7) tick();
        chk_outs("lock_done", 0, 0, 1, 2'd2, 12'h500, 12'hB00, 12'h600);
        dwell = 8'd1; last_prof = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk_outs("lock_p1_kept", 1, 1, 0, 2'd1, P1_PW, P1_PER, P1_PH);
        repeat (3) tick();

        // stop on the second RUN cycle, then start+stop together in IDLE.
        dwell = 8'd5; last_prof = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_outs("stop", 0, 0, 0, 2'd0, P0_PW, P0_PER, P0_PH);
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen = seen | SET | done | busy;
        end
        chk("stop_quiet", {31'd0, seen}, 32'd0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk_outs("start_stop", 0, 0, 0, 2'd0, P0_PW, P0_PER, P0_PH);

        // dwell 0 gives 256 RUN cycles; then reset mid-RUN clears everything.
        dwell = 8'd0; last_prof = 2'd1; loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_set("dwell0_set", 300, n);
        chk("dwell0_period", n, 257);
        chk("dwell0_cur", {30'd0, cur_prof}, 32'd1);
        repeat (10) tick();
        RST = 1'b1; start = 1'b1; wr_en = 1'b1; wr_addr = 4'h0; wr_data = 12'hABC;
        tick();
        RST = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = 4'hC;
        chk_outs("rst_mid", 0, 0, 0, 2'd0, 12'h000, 12'h000, 12'h000);
        dwell = 8'd1; last_prof = 2'd2; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_outs("rst_p0_clr", 1, 1, 0, 2'd0, 12'h000, 12'h000, 12'h000);
        repeat (4) tick();
        chk_outs("rst_p2_clr", 1, 1, 0, 2'd2, 12'h000, 12'h000, 12'h000);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
